// File: rtl/rpc2_ctrl_axi_wdat_packer_pkg.sv
// Shared controller definitions for the write-data path: FIFO word layout and counter widths.
// The packer and the write-data FIFO both use this layout.
package rpc2_ctrl_axi_wdat_packer_pkg;

    localparam int FIFO_WORD_W = 19;
    localparam int DATA_LSB    = 0;
    localparam int DATA_W      = 16;
    localparam int MASK_LSB    = 16;
    localparam int MASK_W      = 2;
    localparam int LAST_BIT    = 18;
    localparam int BEAT_CNT_W  = 8;

    // Packs {last, mask, data} into a FIFO word; a mask bit of 1 means the byte is not written.
    function automatic logic [FIFO_WORD_W-1:0] pack_word(input logic             last,
                                                         input logic [MASK_W-1:0] mask,
                                                         input logic [DATA_W-1:0] data);
        logic [FIFO_WORD_W-1:0] w;
        w                      = '0;
        w[DATA_LSB +: DATA_W]  = data;
        w[MASK_LSB +: MASK_W]  = mask;
        w[LAST_BIT]            = last;
        return w;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_axi_wdat_packer.sv
// Splits AXI W beats into 16-bit memory words with RWDS byte masks and a burst-last tag,
// pushing one word per cycle into the write-data FIFO while it is not full.
module rpc2_ctrl_axi_wdat_packer
    import rpc2_ctrl_axi_wdat_packer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter bit LSB_FIRST      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                          s_wlast,
    output logic                          fifo_wr_en,
    output logic [FIFO_WORD_W-1:0]        fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          burst_done,
    output logic [BEAT_CNT_W-1:0]         beat_cnt
);

    localparam int N  = AXI_DATA_WIDTH / 16;
    localparam int SW = AXI_DATA_WIDTH / 8;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

    logic [AXI_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [SW-1:0]             hold_strb_q, hold_strb_d;
    logic                      hold_last_q, hold_last_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [PW-1:0]             phase_q, phase_d;
    logic [BEAT_CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                      burst_done_q, burst_done_d;

    logic                      is_final;
    logic                      push;
    logic                      accept;
    logic                      last_push;
    logic [MASK_W+DATA_W-1:0]  sel;

    // Returns {mask, data} for the halfword addressed by the phase, honouring emission order.
    function automatic logic [MASK_W+DATA_W-1:0] select_half(input logic [AXI_DATA_WIDTH-1:0] d,
                                                             input logic [SW-1:0]             s,
                                                             input logic [PW-1:0]             ph);
        int idx;
        idx = LSB_FIRST ? int'(ph) : (N - 1 - int'(ph));
        return {~s[2*idx +: 2], d[16*idx +: 16]};
    endfunction

    assign is_final   = (phase_q == LAST_PHASE);
    assign push       = hold_valid_q & ~fifo_full;
    assign s_wready   = ~rst & (~hold_valid_q | (is_final & ~fifo_full));
    assign accept     = s_wvalid & s_wready;
    assign last_push  = push & is_final & hold_last_q;
    assign sel        = select_half(hold_data_q, hold_strb_q, phase_q);

    // The word is forced to zero while idle so stale hold contents never show on the FIFO bus.
    assign fifo_wr_en   = push;
    assign fifo_wr_data = hold_valid_q
                        ? pack_word(hold_last_q & is_final, sel[DATA_W +: MASK_W], sel[DATA_W-1:0])
                        : '0;
    assign burst_done   = burst_done_q;
    assign beat_cnt     = beat_cnt_q;

    // A beat can only be accepted when the hold is empty or its final halfword leaves this cycle,
    // so acceptance always takes priority over advancing the phase.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_strb_d  = hold_strb_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        phase_d      = phase_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = last_push;

        if (accept) begin
            hold_data_d  = s_wdata;
            hold_strb_d  = s_wstrb;
            hold_last_d  = s_wlast;
            hold_valid_d = 1'b1;
            phase_d      = '0;
        end else if (push) begin
            if (is_final) begin
                hold_valid_d = 1'b0;
                phase_d      = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end

        if (last_push) begin
            beat_cnt_d = accept ? BEAT_CNT_W'(1) : '0;
        end else if (accept && (beat_cnt_q != {BEAT_CNT_W{1'b1}})) begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_strb_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            phase_q      <= '0;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_strb_q  <= hold_strb_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            phase_q      <= phase_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

endmodule

// File: tb/tb_rpc2_ctrl_axi_wdat_packer.sv
// Directed bench for the AXI write-data packer: 32-bit LSB-first, 32-bit MSB-first and 64-bit instances.
module tb_rpc2_ctrl_axi_wdat_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 32-bit, LSB first
    logic        v32 = 0, l32 = 0, f32 = 0;
    logic [31:0] d32 = '0;
    logic [3:0]  s32 = '0;
    logic        r32, we32, bd32;
    logic [18:0] wd32;
    logic [7:0]  bc32;

    // 32-bit, MSB first
    logic        vm = 0, lm = 0, fm = 0;
    logic [31:0] dm = '0;
    logic [3:0]  sm = '0;
    logic        rm, wem, bdm;
    logic [18:0] wdm;
    logic [7:0]  bcm;

    // 64-bit, LSB first
    logic        v64 = 0, l64 = 0, f64 = 0;
    logic [63:0] d64 = '0;
    logic [7:0]  s64 = '0;
    logic        r64, we64, bd64;
    logic [18:0] wd64;
    logic [7:0]  bc64;

    rpc2_ctrl_axi_wdat_packer #(.AXI_DATA_WIDTH(32), .LSB_FIRST(1'b1)) dut32 (
        .clk(clk), .rst(rst), .s_wvalid(v32), .s_wready(r32), .s_wdata(d32), .s_wstrb(s32),
        .s_wlast(l32), .fifo_wr_en(we32), .fifo_wr_data(wd32), .fifo_full(f32),
        .burst_done(bd32), .beat_cnt(bc32));

    rpc2_ctrl_axi_wdat_packer #(.AXI_DATA_WIDTH(32), .LSB_FIRST(1'b0)) dutm (
        .clk(clk), .rst(rst), .s_wvalid(vm), .s_wready(rm), .s_wdata(dm), .s_wstrb(sm),
        .s_wlast(lm), .fifo_wr_en(wem), .fifo_wr_data(wdm), .fifo_full(fm),
        .burst_done(bdm), .beat_cnt(bcm));

    rpc2_ctrl_axi_wdat_packer #(.AXI_DATA_WIDTH(64), .LSB_FIRST(1'b1)) dut64 (
        .clk(clk), .rst(rst), .s_wvalid(v64), .s_wready(r64), .s_wdata(d64), .s_wstrb(s64),
        .s_wlast(l64), .fifo_wr_en(we64), .fifo_wr_data(wd64), .fifo_full(f64),
        .burst_done(bd64), .beat_cnt(bc64));

    // Advance to 1 ns after the next rising edge; inputs are then driven and outputs sampled at +1 ns more.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v32 = 1'b1; d32 = 32'hFFFF_FFFF; s32 = 4'hF; l32 = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (r32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_wready: got %b want 0", r32); end
        checks++;
        if (we32 !== 1'b0 || wd32 !== 19'h0) begin
            errors++; $display("[TB] FAIL reset_push: wr_en %b data %h want 0/00000", we32, wd32);
        end
        checks++;
        if (bd32 !== 1'b0 || bc32 !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_cnt: done %b cnt %0d want 0/0", bd32, bc32);
        end
        v32 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (r32 !== 1'b1 || rm !== 1'b1 || r64 !== 1'b1) begin
            errors++; $display("[TB] FAIL release_wready: got %b%b%b want 111", r32, rm, r64);
        end
    endtask

    task automatic test_single_beat();
        tick();
        v32 = 1'b1; d32 = 32'hA1B2_C3D4; s32 = 4'hF; l32 = 1'b1;
        #1;
        checks++;
        if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL single_accept: wready %b want 1", r32); end
        tick();
        v32 = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h0C3D4 || bc32 !== 8'd1) begin
            errors++; $display("[TB] FAIL single_push1: en %b data %h cnt %0d want 1/0c3d4/1", we32, wd32, bc32);
        end
        tick();
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h4A1B2 || bd32 !== 1'b0) begin
            errors++; $display("[TB] FAIL single_push2: en %b data %h done %b want 1/4a1b2/0", we32, wd32, bd32);
        end
        tick();
        #1;
        checks++;
        if (we32 !== 1'b0 || bd32 !== 1'b1 || bc32 !== 8'd0) begin
            errors++; $display("[TB] FAIL single_done: en %b done %b cnt %0d want 0/1/0", we32, bd32, bc32);
        end
        tick();
        #1;
        checks++;
        if (bd32 !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: done %b want 0", bd32); end
    endtask

    // Four-beat burst, then a one-beat burst accepted on the same edge as the first burst's last push.
    task automatic test_back_to_back();
        logic [31:0] beats [5];
        logic [3:0]  strbs [5];
        logic [18:0] words [10];
        int          bi;
        beats = '{32'h1111_0AA0, 32'h3333_2222, 32'h5555_4444, 32'h7777_6666, 32'h9999_8888};
        strbs = '{4'hF, 4'b1101, 4'hF, 4'hF, 4'hF};
        words = '{19'h00AA0, 19'h01111, 19'h22222, 19'h03333, 19'h04444,
                  19'h05555, 19'h06666, 19'h47777, 19'h08888, 19'h49999};
        bi = 0;
        tick();
        for (int c = 0; c <= 11; c++) begin
            v32 = (bi < 5);
            d32 = (bi < 5) ? beats[bi] : 32'h0;
            s32 = (bi < 5) ? strbs[bi] : 4'h0;
            l32 = (bi == 3) || (bi == 4);
            #1;
            if (c <= 8) begin
                checks++;
                if (r32 !== ((c % 2) == 0)) begin
                    errors++; $display("[TB] FAIL b2b_wready c%0d: got %b want %b", c, r32, (c % 2) == 0);
                end
            end
            if (c >= 1 && c <= 10) begin
                checks++;
                if (we32 !== 1'b1 || wd32 !== words[c-1]) begin
                    errors++; $display("[TB] FAIL b2b_push c%0d: en %b data %h want 1/%h", c, we32, wd32, words[c-1]);
                end
                checks++;
                if (bc32 !== ((c <= 8) ? 8'((c + 1) / 2) : 8'd1)) begin
                    errors++; $display("[TB] FAIL b2b_cnt c%0d: got %0d want %0d", c, bc32,
                                       (c <= 8) ? (c + 1) / 2 : 1);
                end
                checks++;
                if (bd32 !== (c == 9)) begin
                    errors++; $display("[TB] FAIL b2b_done c%0d: got %b want %b", c, bd32, c == 9);
                end
            end
            if (c == 11) begin
                checks++;
                if (we32 !== 1'b0 || bd32 !== 1'b1 || bc32 !== 8'd0) begin
                    errors++; $display("[TB] FAIL b2b_end: en %b done %b cnt %0d want 0/1/0", we32, bd32, bc32);
                end
            end
            if (v32 && r32) bi++;
            tick();
        end
        v32 = 1'b0; l32 = 1'b0;
    endtask

    task automatic test_msb_first();
        vm = 1'b1; dm = 32'hDEAD_BEEF; sm = 4'b0110; lm = 1'b1;
        tick();
        vm = 1'b0;
        #1;
        checks++;
        if (wem !== 1'b1 || wdm !== 19'h2DEAD) begin
            errors++; $display("[TB] FAIL msb_push1: en %b data %h want 1/2dead", wem, wdm);
        end
        tick();
        #1;
        checks++;
        if (wem !== 1'b1 || wdm !== 19'h5BEEF) begin
            errors++; $display("[TB] FAIL msb_push2: en %b data %h want 1/5beef", wem, wdm);
        end
        tick();
        #1;
        checks++;
        if (wem !== 1'b0 || bdm !== 1'b1) begin
            errors++; $display("[TB] FAIL msb_done: en %b done %b want 0/1", wem, bdm);
        end
    endtask

    // Low halfword has all-zero strobes and must still be pushed with mask 11.
    task automatic test_stall();
        tick();
        v32 = 1'b1; d32 = 32'hCAFE_F00D; s32 = 4'hC; l32 = 1'b1;
        tick();
        v32 = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h3F00D) begin
            errors++; $display("[TB] FAIL stall_push1: en %b data %h want 1/3f00d", we32, wd32);
        end
        tick();
        f32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (we32 !== 1'b0 || wd32 !== 19'h4CAFE || r32 !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_hold c%0d: en %b data %h rdy %b want 0/4cafe/0", i, we32, wd32, r32);
            end
            tick();
        end
        f32 = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h4CAFE || bd32 !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_resume: en %b data %h done %b want 1/4cafe/0", we32, wd32, bd32);
        end
        tick();
        #1;
        checks++;
        if (we32 !== 1'b0 || bd32 !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_done: en %b done %b want 0/1", we32, bd32);
        end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        v32 = 1'b1; d32 = 32'h1234_5678; s32 = 4'hF; l32 = 1'b0;
        tick();
        v32 = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h05678) begin
            errors++; $display("[TB] FAIL rmid_push1: en %b data %h want 1/05678", we32, wd32);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (we32 !== 1'b0 || wd32 !== 19'h0 || r32 !== 1'b0 || bc32 !== 8'd0 || bd32 !== 1'b0) begin
            errors++; $display("[TB] FAIL rmid_reset: en %b data %h rdy %b cnt %0d done %b want 0/00000/0/0/0",
                               we32, wd32, r32, bc32, bd32);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b0 || wd32 !== 19'h0) begin
            errors++; $display("[TB] FAIL rmid_discard: en %b data %h want 0/00000", we32, wd32);
        end
        tick();
        v32 = 1'b1; d32 = 32'h9ABC_DEF0; s32 = 4'hF; l32 = 1'b1;
        tick();
        v32 = 1'b0;
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h0DEF0 || bc32 !== 8'd1) begin
            errors++; $display("[TB] FAIL rmid_restart: en %b data %h cnt %0d want 1/0def0/1", we32, wd32, bc32);
        end
        tick();
        #1;
        checks++;
        if (we32 !== 1'b1 || wd32 !== 19'h49ABC) begin
            errors++; $display("[TB] FAIL rmid_push2: en %b data %h want 1/49abc", we32, wd32);
        end
        tick();
    endtask

    task automatic test_wide64();
        logic [18:0] words [4];
        words = '{19'h06677, 19'h04455, 19'h32233, 19'h70011};
        v64 = 1'b1; d64 = 64'h0011_2233_4455_6677; s64 = 8'h0F; l64 = 1'b1;
        tick();
        v64 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (we64 !== 1'b1 || wd64 !== words[k] || r64 !== (k == 3) || bc64 !== 8'd1) begin
                errors++; $display("[TB] FAIL w64_push%0d: en %b data %h rdy %b cnt %0d want 1/%h/%b/1",
                                   k, we64, wd64, r64, bc64, words[k], k == 3);
            end
            tick();
        end
        #1;
        checks++;
        if (we64 !== 1'b0 || bd64 !== 1'b1 || bc64 !== 8'd0) begin
            errors++; $display("[TB] FAIL w64_done: en %b done %b cnt %0d want 0/1/0", we64, bd64, bc64);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_msb_first();
        test_stall();
        test_reset_mid_burst();
        test_wide64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
